// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its command source, the async FIFO
// read port and the downstream stream sink.
interface fifo_burst_reader_if #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_W     = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_r_data;
    logic                 fifo_r_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    modport master (
        input  cmd_valid, cmd_len, fifo_empty, fifo_r_data, out_ready,
        output cmd_ready, fifo_r_en, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_empty, fifo_r_data, out_ready,
        input  cmd_ready, fifo_r_en, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst consumer for the read side of the async FIFO: pops N words into a
// 2-entry skid buffer and streams them out with last-beat marking.
module fifo_burst_reader #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_W     = 8
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    fifo_burst_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic [LEN_W-1:0]     sent_left_q, sent_left_d;
    logic [1:0]           buf_cnt_q, buf_cnt_d;
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] tail_q, tail_d;
    logic                 pop;
    logic                 beat_hs;
    logic                 out_valid;

    // Pop only on current occupancy; no look-ahead on out_ready keeps the
    // FIFO read path short and makes popping an empty FIFO impossible.
    assign pop       = (state_q == READ) && !bus.fifo_empty &&
                       (remaining_q != '0) && (buf_cnt_q < 2'd2);
    assign out_valid = (buf_cnt_q != 2'd0);
    assign beat_hs   = out_valid && bus.out_ready;

    assign bus.fifo_r_en = pop;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_q;
    assign bus.out_last  = out_valid && (sent_left_q == LEN_ONE);
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == READ) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sent_left_d = sent_left_q;

        if (pop) begin
            remaining_d = remaining_q - LEN_ONE;
        end
        if (beat_hs && (sent_left_q != '0)) begin
            sent_left_d = sent_left_q - LEN_ONE;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    remaining_d = bus.cmd_len;
                    sent_left_d = bus.cmd_len;
                    state_d     = (bus.cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (remaining_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sent_left_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: head feeds the output, tail catches a pop while head stalls.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        buf_cnt_d = buf_cnt_q;

        case ({pop, beat_hs})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    head_d = bus.fifo_r_data;
                end else begin
                    tail_d = bus.fifo_r_data;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d    = tail_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    head_d = bus.fifo_r_data;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_r_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sent_left_q <= '0;
            buf_cnt_q   <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sent_left_q <= sent_left_d;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO read port.
module tb_fifo_burst_reader;
    logic r_clk = 1'b0;
    logic r_rst_n;

    always #5 r_clk = ~r_clk;

    fifo_burst_reader_if #(.DATA_SIZE(8), .LEN_W(8)) bus ();

    fifo_burst_reader #(.DATA_SIZE(8), .LEN_W(8)) dut (
        .r_clk   (r_clk),
        .r_rst_n (r_rst_n),
        .bus     (bus)
    );

    // Behavioural FIFO: combinational head, pointer advances on pop
    logic [7:0] mem [256];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    assign bus.fifo_empty  = (rd_ptr == wr_ptr);
    assign bus.fifo_r_data = mem[rd_ptr];

    always @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            rd_ptr <= 8'd0;
        end else if (bus.fifo_r_en) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    // Observation, sampled mid-cycle on the falling edge
    int         cyc = 0;
    logic       clr;
    int         pops, empty_pops, hs_cnt, valid_seen, unstable, max_ahead;
    logic       hold_pend;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [7:0] beat_q[$];
    bit         last_q[$];
    int         hs_cyc_q[$];
    int         done_q[$];
    int         acc_q[$];
    int         ahead_now;

    assign ahead_now = pops - hs_cnt;

    always @(negedge r_clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            pops       <= 0;
            empty_pops <= 0;
            hs_cnt     <= 0;
            valid_seen <= 0;
            unstable   <= 0;
            max_ahead  <= 0;
            hold_pend  <= 1'b0;
            beat_q.delete();
            last_q.delete();
            hs_cyc_q.delete();
            done_q.delete();
            acc_q.delete();
        end else begin
            if (bus.fifo_r_en) begin
                pops <= pops + 1;
                if (bus.fifo_empty) empty_pops <= empty_pops + 1;
            end
            if (bus.out_valid) valid_seen <= valid_seen + 1;
            if (bus.out_valid && bus.out_ready) begin
                beat_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
                hs_cyc_q.push_back(cyc);
                hs_cnt <= hs_cnt + 1;
            end
            if (bus.done) done_q.push_back(cyc);
            if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
            if (hold_pend && (bus.out_data !== hold_data || bus.out_valid !== 1'b1 ||
                              bus.out_last !== hold_last)) begin
                unstable <= unstable + 1;
            end
            hold_pend <= bus.out_valid && !bus.out_ready;
            hold_data <= bus.out_data;
            hold_last <= bus.out_last;
            if (ahead_now > max_ahead) max_ahead <= ahead_now;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic issue(input logic [7:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run(input int ndone, input logic [15:0] pat, input int budget);
        int k;
        k = 0;
        while (done_q.size() < ndone && k < budget) begin
            bus.out_ready = pat[k[3:0]];
            tick();
            k++;
        end
        check("done_reached", (done_q.size() >= ndone), 1);
    endtask

    typedef struct {
        logic [7:0]  len;
        logic [7:0]  base;
        logic [15:0] pat;
        bit          full_rate;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        int k;

        vecs[0] = '{len: 8'd4, base: 8'h10, pat: 16'hFFFF, full_rate: 1'b1};
        vecs[1] = '{len: 8'd5, base: 8'h20, pat: 16'h9999, full_rate: 1'b0};
        vecs[2] = '{len: 8'd1, base: 8'h30, pat: 16'hFFFF, full_rate: 1'b1};
        vecs[3] = '{len: 8'd7, base: 8'h40, pat: 16'h5555, full_rate: 1'b0};

        r_rst_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 8'd0;
        bus.out_ready = 1'b0;
        wr_ptr        = 8'd0;
        clr           = 1'b1;
        repeat (3) tick();

        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_fifo_r_en", bus.fifo_r_en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_done",      bus.done, 0);
        check("rst_out_data",  bus.out_data, 0);

        r_rst_n = 1'b1;
        tick();
        clr = 1'b0;

        for (int n = 0; n < 4; n++) begin
            clear();
            for (int i = 0; i < int'(vecs[n].len); i++) push_word(vecs[n].base + 8'(i));
            bus.out_ready = vecs[n].pat[0];
            issue(vecs[n].len);
            run(1, vecs[n].pat, 300);
            check("vec_beats", beat_q.size(), vecs[n].len);
            for (int i = 0; i < int'(vecs[n].len); i++) begin
                check("vec_data", beat_q[i], vecs[n].base + 8'(i));
                check("vec_last", last_q[i], (i == int'(vecs[n].len) - 1));
            end
            check("vec_pops", pops, vecs[n].len);
            check("vec_empty_pop", empty_pops, 0);
            check("vec_stable", unstable, 0);
            check("vec_ahead_le2", (max_ahead <= 2), 1);
            check("vec_one_done", done_q.size(), 1);
            if (vecs[n].full_rate) begin
                check("vec_latency", hs_cyc_q[0], acc_q[0] + 2);
                check("vec_span", hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[0], vecs[n].len - 1);
                check("vec_done_time", done_q[0], hs_cyc_q[hs_cyc_q.size()-1] + 1);
            end
            check("vec_cmd_ready", bus.cmd_ready, 1);
        end

        // Zero-length command
        clear();
        bus.out_ready = 1'b1;
        issue(8'd0);
        run(1, 16'hFFFF, 20);
        check("zero_pops", pops, 0);
        check("zero_valid", valid_seen, 0);
        check("zero_done_time", done_q[0], acc_q[0] + 1);
        check("zero_cmd_ready", bus.cmd_ready, 1);

        // FIFO runs dry mid-burst, then refills
        clear();
        push_word(8'hA0);
        push_word(8'hA1);
        bus.out_ready = 1'b1;
        issue(8'd4);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.busy) gap++;
        end
        check("stall_pops", pops, 2);
        push_word(8'hA2);
        push_word(8'hA3);
        k = 0;
        while (done_q.size() < 1 && k < 100) begin
            tick();
            if (!bus.busy && !bus.done && done_q.size() == 0) gap++;
            k++;
        end
        check("stall_done", done_q.size(), 1);
        check("stall_busy_gap", gap, 0);
        check("stall_empty_pop", empty_pops, 0);
        check("stall_beats", beat_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("stall_data", beat_q[i], 8'hA0 + 8'(i));
            check("stall_last", last_q[i], (i == 3));
        end

        // Back-to-back commands with cmd_valid held high
        clear();
        for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
        bus.out_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd3;
        tick();
        bus.cmd_len = 8'd2;
        k = 0;
        while (acc_q.size() < 2 && k < 100) begin
            tick();
            k++;
        end
        bus.cmd_valid = 1'b0;
        run(2, 16'hFFFF, 100);
        check("b2b_accepts", acc_q.size(), 2);
        check("b2b_second_acc", acc_q[1], done_q[0] + 1);
        check("b2b_beats", beat_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("b2b_data", beat_q[i], 8'h50 + 8'(i));
            check("b2b_last", last_q[i], (i == 2 || i == 4));
        end

        // Reset mid-burst discards buffered words
        clear();
        for (int i = 0; i < 6; i++) push_word(8'h70 + 8'(i));
        bus.out_ready = 1'b1;
        issue(8'd6);
        tick();
        check("mid_pre_r_en", bus.fifo_r_en, 1);
        check("mid_pre_valid", bus.out_valid, 1);
        check("mid_pre_busy", bus.busy, 1);
        #2;
        r_rst_n = 1'b0;
        wr_ptr  = 8'd0;
        #1;
        check("mid_r_en", bus.fifo_r_en, 0);
        check("mid_valid", bus.out_valid, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        check("mid_data", bus.out_data, 0);
        tick();
        r_rst_n = 1'b1;
        tick();
        check("post_cmd_ready", bus.cmd_ready, 1);
        check("post_valid", bus.out_valid, 0);
        clear();
        for (int i = 0; i < 3; i++) push_word(8'h80 + 8'(i));
        issue(8'd3);
        run(1, 16'hFFFF, 50);
        check("post_beats", beat_q.size(), 3);
        for (int i = 0; i < 3; i++) check("post_data", beat_q[i], 8'h80 + 8'(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
